fpu_cvt_sched: RTL and testbench

Round-robin issue scheduler that shares one `ftoi` pipeline and one `itof` pipeline among `NREQ` requesters.
- Accepts conversion requests over valid/ready handshakes and drives the same operand into both units.
- Tracks each in-flight op's opcode, tag and source through a fixed-latency valid/tag pipeline.
- Returns results in issue order through a credit-protected response FIFO.
- Sits between the core issue stage and the FPU conversion units; neither unit can stall, so all flow control happens here.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_resp_fifo.sv | 51 +++++
 rtl/fpu_cvt_sched.sv | 134 +++++++++++++
 tb/tb_fpu_cvt_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode and in-flight metadata types for the conversion scheduler.
package fpu_pkg;

   // Widest tag and requester index carried through the meta pipe.
   localparam int CVT_TAGW = 8;
   localparam int CVT_SRCW = 2;

   typedef enum logic {
      CVT_FTOI = 1'b0,
      CVT_ITOF = 1'b1
   } cvt_op_e;

   typedef struct packed {
      logic                valid;
      cvt_op_e             op;
      logic [CVT_TAGW-1:0] tag;
      logic [CVT_SRCW-1:0] src;
   } cvt_meta_t;

endpackage

// File: rtl/fpu_resp_fifo.sv
// fpu_resp_fifo: synchronous response FIFO with occupancy count; storage is not reset.
module fpu_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fpu_cvt_sched.sv
// fpu_cvt_sched: round-robin issue onto shared ftoi/itof pipelines with credit-protected,
// in-order responses. Define FPU_CVT_BYPASS_EN to let a result skip the empty FIFO.
module fpu_cvt_sched
   import fpu_pkg::*;
#(
   parameter int NSTAGE     = 2,
   parameter int NREQ       = 2,
   parameter int TAGW       = 5,
   parameter int OBUF_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ-1:0]           req_op,
   input  logic [NREQ-1:0][31:0]     req_data,
   input  logic [NREQ-1:0][TAGW-1:0] req_tag,
   output logic [31:0]               cvt_x,
   input  logic [31:0]               ftoi_y,
   input  logic [31:0]               itof_y,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [31:0]               resp_data,
   output logic [TAGW-1:0]           resp_tag,
   output logic [$clog2(NREQ)-1:0]   resp_src
);

   localparam int SRCW = $clog2(NREQ);
   localparam int CNTW = $clog2(OBUF_DEPTH) + 1;
   localparam int RSPW = 32 + TAGW + SRCW;

   cvt_meta_t          meta_p [NSTAGE+1];
   cvt_meta_t          meta_in;
   cvt_meta_t          wb;
   logic [SRCW-1:0]    rr_ptr;
   logic [SRCW-1:0]    grant_idx;
   logic               grant_any;
   logic [15:0]        inflight;
   logic signed [15:0] credit;
   logic [CNTW-1:0]    fifo_count;
   logic               fifo_empty;
   logic               fifo_full;
   logic               fifo_push;
   logic               fifo_pop;
   logic [RSPW-1:0]    fifo_din;
   logic [RSPW-1:0]    fifo_dout;
   logic [RSPW-1:0]    head;
   logic [31:0]        wb_data;
   logic               meta_unused;

   // Every op issued but not yet popped holds a FIFO slot; registered state only.
   always_comb begin
      inflight = '0;
      for (int s = 0; s <= NSTAGE; s++) inflight = inflight + 16'(meta_p[s].valid);
      credit = signed'(16'(OBUF_DEPTH) - 16'(fifo_count) - inflight);
   end

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      if (rstn && credit > 16'sd0) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
               grant_any = 1'b1;
               grant_idx = SRCW'((int'(rr_ptr) + k) % NREQ);
            end
         end
      end
      req_ready = '0;
      if (grant_any) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      meta_in       = '0;
      meta_in.valid = grant_any;
      meta_in.op    = cvt_op_e'(req_op[grant_idx]);
      meta_in.tag   = CVT_TAGW'(req_tag[grant_idx]);
      meta_in.src   = CVT_SRCW'(grant_idx);
   end

   // Stage 0 pairs with cvt_x; stage NSTAGE lines up with the unit results.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cvt_x  <= '0;
         rr_ptr <= '0;
         for (int s = 0; s <= NSTAGE; s++) meta_p[s] <= '0;
      end else begin
         if (grant_any) begin
            cvt_x  <= req_data[grant_idx];
            rr_ptr <= SRCW'((int'(grant_idx) + 1) % NREQ);
         end
         meta_p[0] <= meta_in;
         for (int s = 1; s <= NSTAGE; s++) meta_p[s] <= meta_p[s-1];
      end
   end

   // Writeback stage
   assign wb          = meta_p[NSTAGE];
   assign wb_data     = (wb.op == CVT_FTOI) ? ftoi_y : itof_y;
   assign fifo_din    = {wb_data, TAGW'(wb.tag), SRCW'(wb.src)};
   assign meta_unused = ^{wb.tag, wb.src};

   always_comb begin
`ifdef FPU_CVT_BYPASS_EN
      resp_valid = !fifo_empty || wb.valid;
      head       = fifo_empty ? fifo_din : fifo_dout;
      fifo_push  = wb.valid && !(fifo_empty && resp_ready);
`else
      resp_valid = !fifo_empty;
      head       = fifo_dout;
      fifo_push  = wb.valid;
`endif
      fifo_pop = !fifo_empty && resp_ready;
      {resp_data, resp_tag, resp_src} = resp_valid ? head : '0;
   end

   fpu_resp_fifo #(
      .DEPTH (OBUF_DEPTH),
      .WIDTH (RSPW)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_fpu_cvt_sched.sv
// tb_fpu_cvt_sched: directed bench for fpu_cvt_sched with stub ftoi/itof units of NSTAGE cycles.
module tb_fpu_cvt_sched;

   localparam int NSTAGE = 2;
`ifdef FPU_CVT_BYPASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic            clk;
   logic            rstn;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0]      req_op;
   logic [1:0][31:0] req_data;
   logic [1:0][4:0] req_tag;
   logic [31:0]     cvt_x;
   logic [31:0]     ftoi_y;
   logic [31:0]     itof_y;
   logic            resp_valid;
   logic            resp_ready;
   logic [31:0]     resp_data;
   logic [4:0]      resp_tag;
   logic [0:0]      resp_src;

   int nvec = 0;
   int nmis = 0;
   int lat, nacc, stale, ng, ncol;
   logic [1:0]  gnow;
   logic [1:0]  gseq  [8];
   logic [31:0] got_d [8];
   logic [4:0]  got_t [8];
   logic [0:0]  got_s [8];
   logic [31:0] u_p   [NSTAGE];

   fpu_cvt_sched #(.NSTAGE(NSTAGE), .NREQ(2), .TAGW(5), .OBUF_DEPTH(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_data   (req_data),
      .req_tag    (req_tag),
      .cvt_x      (cvt_x),
      .ftoi_y     (ftoi_y),
      .itof_y     (itof_y),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag),
      .resp_src   (resp_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in conversion units: exact results for the directed operands, a marker otherwise.
   function automatic logic [31:0] ftoi_model(input logic [31:0] x);
      case (x)
         32'h40490FDB: return 32'd3;
         32'h3FC00000: return 32'd2;
         32'hBFC00000: return 32'hFFFFFFFE;
         default:      return x + 32'h0000_1000;
      endcase
   endfunction

   function automatic logic [31:0] itof_model(input logic [31:0] x);
      case (x)
         32'h00000007: return 32'h40E00000;
         default:      return ~x;
      endcase
   endfunction

   always @(posedge clk) begin
      u_p[0] <= cvt_x;
      for (int s = 1; s < NSTAGE; s++) u_p[s] <= u_p[s-1];
   end
   assign ftoi_y = ftoi_model(u_p[NSTAGE-1]);
   assign itof_y = itof_model(u_p[NSTAGE-1]);

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %h, expected %h", name, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (!resp_valid && n < 10) begin
         cyc();
         #1;
         n++;
      end
   endtask

   // Records grants and fired responses each cycle until both targets are met or budget expires.
   task automatic run(input int ng_t, input int nr_t, input bit oneshot);
      ng   = 0;
      ncol = 0;
      for (int c = 0; c < 40 && (ng < ng_t || ncol < nr_t); c++) begin
         #1;
         gnow = req_ready;
         if (gnow != 2'b00 && ng < 8) begin
            gseq[ng] = gnow;
            ng++;
         end
         if (resp_valid && resp_ready && ncol < 8) begin
            got_d[ncol] = resp_data;
            got_t[ncol] = resp_tag;
            got_s[ncol] = resp_src;
            ncol++;
         end
         cyc();
         if (oneshot) req_valid = req_valid & ~gnow;
         if (ng >= ng_t) req_valid = 2'b00;
      end
      req_valid = 2'b00;
   endtask

   initial begin
      rstn       = 1'b0;
      req_valid  = 2'b00;
      req_op     = 2'b00;
      req_data   = '0;
      req_tag    = '0;
      resp_ready = 1'b0;

      // Reset values, with requests asserted to show req_ready is held low
      cyc();
      cyc();
      req_valid = 2'b11;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_cvt_x", cvt_x, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_tag", 32'(resp_tag), 32'd0);
      chk("rst_resp_src", 32'(resp_src), 32'd0);
      req_valid = 2'b00;
      rstn = 1'b1;
      cyc();

      // Single FTOI on req0
      req_valid   = 2'b01;
      req_op[0]   = 1'b0;
      req_data[0] = 32'h40490FDB;
      req_tag[0]  = 5'd5;
      #1;
      chk("t1_grant", 32'(req_ready), 32'h1);
      cyc();
      req_valid = 2'b00;
      #1;
      chk("t1_cvt_x", cvt_x, 32'h40490FDB);
      wait_resp(lat);
      chk("t1_latency", lat, LAT);
      chk("t1_data", resp_data, 32'd3);
      chk("t1_tag", 32'(resp_tag), 32'd5);
      chk("t1_src", 32'(resp_src), 32'd0);
      resp_ready = 1'b1;
      cyc();
      resp_ready = 1'b0;
      #1;
      chk("t1_drained", 32'(resp_valid), 32'd0);

      // Rounding and ITOF, back to back on req0
      resp_ready  = 1'b1;
      req_valid   = 2'b01;
      req_op[0]   = 1'b0;
      req_data[0] = 32'h3FC00000;
      req_tag[0]  = 5'd1;
      cyc();
      req_data[0] = 32'hBFC00000;
      req_tag[0]  = 5'd2;
      cyc();
      req_op[0]   = 1'b1;
      req_data[0] = 32'h00000007;
      req_tag[0]  = 5'd3;
      cyc();
      req_valid = 2'b00;
      run(0, 3, 1'b0);
      chk("t2_count", ncol, 32'd3);
      chk("t2_pos_half", got_d[0], 32'd2);
      chk("t2_tag0", 32'(got_t[0]), 32'd1);
      chk("t2_neg_half", got_d[1], 32'hFFFFFFFE);
      chk("t2_tag1", 32'(got_t[1]), 32'd2);
      chk("t2_itof", got_d[2], 32'h40E00000);
      chk("t2_tag2", 32'(got_t[2]), 32'd3);

      // Backpressure: credits cap accepts at the FIFO depth
      resp_ready  = 1'b0;
      req_valid   = 2'b01;
      req_op[0]   = 1'b0;
      req_data[0] = 32'h00000300;
      req_tag[0]  = 5'd7;
      nacc = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (req_ready[0]) nacc++;
         cyc();
      end
      chk("bp_accepts", nacc, 32'd4);
      chk("bp_stalled", 32'(req_ready), 32'd0);
      resp_ready = 1'b1;
      #1;
      chk("bp_stall_at_pop", 32'(req_ready), 32'd0);
      cyc();
      resp_ready = 1'b0;
      #1;
      chk("bp_reaccept", 32'(req_ready), 32'h1);
      cyc();
      #1;
      chk("bp_restall", 32'(req_ready), 32'd0);
      req_valid  = 2'b00;
      resp_ready = 1'b1;
      run(0, 4, 1'b0);
      chk("bp_drain_count", ncol, 32'd4);
      chk("bp_drain_data", got_d[3], 32'h00001300);
      chk("bp_drain_tag", 32'(got_t[3]), 32'd7);

      // Reset with two buffered and two in flight
      resp_ready  = 1'b0;
      req_valid   = 2'b01;
      req_data[0] = 32'h00000400;
      req_tag[0]  = 5'd4;
      repeat (4) cyc();
      req_valid = 2'b00;
      cyc();
      #1;
      chk("mr_pre_valid", 32'(resp_valid), 32'd1);
      rstn      = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("mr_resp_valid", 32'(resp_valid), 32'd0);
      chk("mr_req_ready", 32'(req_ready), 32'd0);
      chk("mr_cvt_x", cvt_x, 32'd0);
      chk("mr_resp_data", resp_data, 32'd0);
      cyc();
      cyc();
      req_valid  = 2'b00;
      rstn       = 1'b1;
      resp_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (resp_valid) stale++;
         cyc();
      end
      chk("mr_no_stale", stale, 32'd0);
      req_valid   = 2'b10;
      req_op[1]   = 1'b1;
      req_data[1] = 32'h00000007;
      req_tag[1]  = 5'd9;
      cyc();
      req_valid = 2'b00;
      #1;
      wait_resp(lat);
      chk("mr_latency", lat, LAT);
      chk("mr_data", resp_data, 32'h40E00000);
      chk("mr_tag", 32'(resp_tag), 32'd9);
      chk("mr_src", 32'(resp_src), 32'd1);
      cyc();

      // Contention: both requesters held valid
      req_op      = 2'b00;
      req_data[0] = 32'h00000100;
      req_tag[0]  = 5'd10;
      req_data[1] = 32'h00000200;
      req_tag[1]  = 5'd11;
      req_valid   = 2'b11;
      run(4, 4, 1'b0);
      chk("ct_grant0", 32'(gseq[0]), 32'h1);
      chk("ct_grant1", 32'(gseq[1]), 32'h2);
      chk("ct_grant2", 32'(gseq[2]), 32'h1);
      chk("ct_grant3", 32'(gseq[3]), 32'h2);
      chk("ct_count", ncol, 32'd4);
      chk("ct_src0", 32'(got_s[0]), 32'd0);
      chk("ct_src1", 32'(got_s[1]), 32'd1);
      chk("ct_src2", 32'(got_s[2]), 32'd0);
      chk("ct_src3", 32'(got_s[3]), 32'd1);
      chk("ct_data1", got_d[1], 32'h00001200);
      chk("ct_tag2", 32'(got_t[2]), 32'd10);

      // Op/tag mixing across requesters
      req_op[0]   = 1'b0;
      req_data[0] = 32'h3FC00000;
      req_tag[0]  = 5'd1;
      req_op[1]   = 1'b1;
      req_data[1] = 32'h00000007;
      req_tag[1]  = 5'd2;
      req_valid   = 2'b11;
      run(2, 2, 1'b1);
      chk("mx_count", ncol, 32'd2);
      chk("mx_ftoi_data", got_d[0], 32'd2);
      chk("mx_ftoi_tag", 32'(got_t[0]), 32'd1);
      chk("mx_ftoi_src", 32'(got_s[0]), 32'd0);
      chk("mx_itof_data", got_d[1], 32'h40E00000);
      chk("mx_itof_tag", 32'(got_t[1]), 32'd2);
      chk("mx_itof_src", 32'(got_s[1]), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
